key_debounce_scan: RTL and testbench



---
 rtl/key_pkg.sv | 27 ++
 rtl/key_sync2.sv | 25 ++
 rtl/key_debounce_scan.sv | 170 +++++++++++++++++
 tb/tb_key_debounce_scan.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the push-button front-end and the mode-selection
// stage that consumes its key_flag / key_value strobe.
package key_pkg;

  // Debounce FSM states; key_busy is high whenever the FSM is not IDLE.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_state_e;

  // Key masks that step the Sobel grade down / up in the mode-selection stage.
  localparam logic [3:0] KEY_DEC = 4'b0100;
  localparam logic [3:0] KEY_INC = 4'b1000;

  // 20 ms at 100 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 2_000_000;

  // Largest of three timing constants; sizes the shared saturating counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchroniser for asynchronous, active-low key pins.
// Both stages reset to all-ones so every key reads as released out of reset.
module key_sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  // Two-stage capture of the raw pins into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      q      <= '1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/key_debounce_scan.sv
// Push-button front-end: synchronises active-low key pins, debounces press
// and release, and emits a single-cycle key_flag with the pressed-key mask.
//
// Optional build macro KEY_REPEAT_EN: while a combination is held, emit a
// first auto-repeat flag after REPEAT_DELAY cycles and then one every
// REPEAT_PERIOD cycles. Without it, HELD produces no flags.
//
// Output interface: key_flag is a one-cycle valid strobe with no ready; the
// consumer takes key_value in the flag cycle (or any later cycle, since
// key_value holds until the next flag). key_flag never asserts on two
// consecutive cycles.
module key_debounce_scan
  import key_pkg::*;
#(
  parameter int KEY_NUM         = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic               key_flag,
  output logic [KEY_NUM-1:0] key_value,
  output logic               key_busy
);

  localparam int CNT_RANGE = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CNT_W     = $clog2(CNT_RANGE + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  // A debounce window shorter than two cycles cannot be represented.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce_scan: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [KEY_NUM-1:0] key_sync;
  logic               all_up;

  key_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [KEY_NUM-1:0] snap_q, snap_d;
  logic               flag_d;
  logic [KEY_NUM-1:0] value_d;
`ifdef KEY_REPEAT_EN
  // 0: waiting out REPEAT_DELAY, 1: repeating every REPEAT_PERIOD.
  logic               rpt_phase_q, rpt_phase_d;
`endif

  key_sync2 #(.WIDTH(KEY_NUM)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (key_sync)
  );

  assign all_up   = &key_sync;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign key_busy = (state_q != IDLE);

  // State, counter, snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      snap_q      <= '1;
      key_flag    <= 1'b0;
      key_value   <= '0;
`ifdef KEY_REPEAT_EN
      rpt_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      key_flag    <= flag_d;
      key_value   <= value_d;
`ifdef KEY_REPEAT_EN
      rpt_phase_q <= rpt_phase_d;
`endif
    end
  end

  // Next-state, counter and flag decisions from the synchronised pins.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    snap_d      = snap_q;
    flag_d      = 1'b0;
    value_d     = key_value;
`ifdef KEY_REPEAT_EN
    rpt_phase_d = rpt_phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (!all_up) begin
          snap_d  = key_sync;
          cnt_d   = '0;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (all_up) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (key_sync != snap_q) begin
          // Combination still settling: restart the window on the new one.
          snap_d = key_sync;
          cnt_d  = '0;
        end else if (cnt_q == DB_LAST) begin
          flag_d  = 1'b1;
          value_d = ~snap_q;
          cnt_d   = '0;
          state_d = HELD;
`ifdef KEY_REPEAT_EN
          rpt_phase_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (all_up) begin
          cnt_d   = '0;
          state_d = REL_DB;
        end
`ifdef KEY_REPEAT_EN
        else if (key_sync != snap_q) begin
          // New combination: start the initial repeat delay over.
          snap_d      = key_sync;
          cnt_d       = '0;
          rpt_phase_d = 1'b0;
        end else if (cnt_q == (rpt_phase_q ? PER_LAST : DLY_LAST)) begin
          flag_d      = 1'b1;
          value_d     = ~key_sync;
          cnt_d       = '0;
          rpt_phase_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      REL_DB: begin
        if (!all_up) begin
          // Release bounce: back to HELD without a new flag.
          cnt_d   = '0;
          state_d = HELD;
`ifdef KEY_REPEAT_EN
          snap_d      = key_sync;
          rpt_phase_d = 1'b0;
`endif
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_debounce_scan.sv
// Bench for key_debounce_scan with short timing constants. A run-length
// reference model predicts key_flag / key_value / key_busy every cycle;
// directed scenarios additionally check flag counts, masks and latencies.
module tb_key_debounce_scan;
  import key_pkg::*;

  localparam int DEB  = 16;
  localparam int RD   = 40;
  localparam int RP   = 10;
  localparam int WIN  = DEB + 1;
  localparam logic [3:0] ONES = 4'b1111;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic       key_flag;
  logic [3:0] key_value;
  logic       key_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  key_debounce_scan #(
    .KEY_NUM         (4),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_value (key_value),
    .key_busy  (key_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // s is what the debouncer sees at an edge: key_in two edges earlier.
  // A press is accepted when WIN equal non-released samples in a row are
  // seen while armed; re-arming needs WIN released samples in a row.
  logic [3:0] d1, d2, s, prev_s;
  int         run;
  bit         armed;
  int         epoch;
  bit         m_flag;
  logic [3:0] m_value;
  bit         m_busy;

  task automatic reset_model();
    d1 = ONES; d2 = ONES; s = ONES; prev_s = ONES;
    run = 0; armed = 1'b1; epoch = 0;
    m_flag = 1'b0; m_value = 4'b0000; m_busy = 1'b0;
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        reset_model();
      end else begin
        cyc++;
        s  = d2;
        d2 = d1;
        d1 = key_in;
        if (s == prev_s) run = (run < 100000) ? run + 1 : run;
        else             run = 1;
        m_flag = 1'b0;
        if (armed) begin
          if (s != ONES && run >= WIN) begin
            m_flag = 1'b1; m_value = ~s; armed = 1'b0; epoch = cyc;
          end
        end else begin
          if (s == ONES) begin
            if (run >= WIN) armed = 1'b1;
          end else if (s != prev_s) begin
            epoch = cyc;
          end
`ifdef KEY_REPEAT_EN
          else if ((cyc - epoch) >= RD && ((cyc - epoch - RD) % RP) == 0) begin
            m_flag = 1'b1; m_value = ~s;
          end
`endif
        end
        m_busy = !(armed && s == ONES);
        prev_s = s;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [3:0] exp_q[$];
  int         flag_cyc_q[$];
  bit         sb_on = 1'b0;
  bit         prev_busy = 1'b0;
  int         last_busy_fall = 0;

  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("flag", key_flag, m_flag);
        check("value", key_value, m_value);
        check("busy", key_busy, m_busy);
        if (key_flag) begin
          flag_cyc_q.push_back(cyc);
          if (sb_on && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_value", key_value, e);
          end
        end
        if (prev_busy && !key_busy) last_busy_fall = cyc;
        prev_busy = key_busy;
      end else begin
        prev_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int t_drive = 0;

  task automatic drive(input logic [3:0] v, input int n);
    @(negedge clk);
    key_in  = v;
    t_drive = cyc;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic start_scn();
    flag_cyc_q.delete();
    exp_q.delete();
    sb_on = 1'b1;
  endtask

  // Latency is counted from the first clock edge that samples the new level.
  function automatic int lat(input int obs, input int t0);
    return obs - (t0 + 1);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int t_a, t_b;
    logic [3:0] mask;
    rst_n  = 1'b0;
    key_in = ONES;
    repeat (3) @(negedge clk);
    check("reset_flag", key_flag, 1'b0);
    check("reset_value", key_value, 4'b0000);
    check("reset_busy", key_busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Glitch shorter than the window: no flag, value untouched.
    start_scn();
    drive(4'b1011, 10);
    drive(ONES, 30);
    check("glitch_count", flag_cyc_q.size(), 0);
    check("glitch_value", key_value, 4'b0000);
    check("glitch_idle", key_busy, 1'b0);

    // Clean press and release.
    start_scn();
    exp_q.push_back(KEY_DEC);
    drive(4'b1011, 30); t_a = t_drive;
    drive(ONES, 30);    t_b = t_drive;
    check("clean_count", flag_cyc_q.size(), 1);
    if (flag_cyc_q.size() > 0) check("clean_latency", lat(flag_cyc_q[0], t_a), DEB + 2);
    check("clean_busy_release", lat(last_busy_fall, t_b), DEB + 2);
    check("clean_sb_empty", exp_q.size(), 0);

    // Bouncing press on bit3.
    start_scn();
    exp_q.push_back(KEY_INC);
    for (int i = 0; i < 8; i++) drive((i % 2 == 0) ? 4'b0111 : ONES, 5);
    drive(4'b0111, 30); t_a = t_drive;
    drive(ONES, 30);
    check("bounce_count", flag_cyc_q.size(), 1);
    if (flag_cyc_q.size() > 0) check("bounce_latency", lat(flag_cyc_q[0], t_a), DEB + 2);
    check("bounce_sb_empty", exp_q.size(), 0);

    // Two keys pressed 4 cycles apart, then partial release.
    start_scn();
    exp_q.push_back(4'b1100);
    drive(4'b1011, 4);
    drive(4'b0011, 30); t_a = t_drive;
    drive(4'b0111, 30);
    check("two_keys_value_held", key_value, 4'b1100);
    drive(ONES, 30);
    check("two_keys_count", flag_cyc_q.size(), 1);
    if (flag_cyc_q.size() > 0) check("two_keys_latency", lat(flag_cyc_q[0], t_a), DEB + 2);
    check("two_keys_sb_empty", exp_q.size(), 0);

    // Release with three bounces.
    start_scn();
    exp_q.push_back(4'b0001);
    drive(4'b1110, 30);
    for (int i = 0; i < 3; i++) begin
      drive(ONES, 6);
      drive(4'b1110, 2);
    end
    drive(ONES, 30); t_b = t_drive;
    check("rel_bounce_count", flag_cyc_q.size(), 1);
    check("rel_bounce_idle", lat(last_busy_fall, t_b), DEB + 2);
    check("rel_bounce_sb_empty", exp_q.size(), 0);

    // Reset in the middle of the press window, key still held afterwards.
    start_scn();
    exp_q.push_back(4'b0010);
    drive(4'b1101, 1);
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_flag", key_flag, 1'b0);
    check("rst_mid_value", key_value, 4'b0000);
    check("rst_mid_busy", key_busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t_a = cyc;
    repeat (30) @(negedge clk);
    drive(ONES, 30);
    check("rst_mid_count", flag_cyc_q.size(), 1);
    if (flag_cyc_q.size() > 0) check("rst_mid_latency", lat(flag_cyc_q[0], t_a), DEB + 2);
    check("rst_mid_sb_empty", exp_q.size(), 0);

`ifdef KEY_REPEAT_EN
    // Long hold: first flag, delayed repeat, then periodic repeats.
    start_scn();
    for (int i = 0; i < 8; i++) exp_q.push_back(KEY_INC);
    drive(4'b0111, 120); t_a = t_drive;
    drive(ONES, 30);
    check("repeat_count", flag_cyc_q.size(), 8);
    if (flag_cyc_q.size() >= 3) begin
      check("repeat_first", lat(flag_cyc_q[0], t_a), DEB + 2);
      check("repeat_delay", flag_cyc_q[1] - flag_cyc_q[0], RD);
      check("repeat_period", flag_cyc_q[2] - flag_cyc_q[1], RP);
    end
    check("repeat_sb_empty", exp_q.size(), 0);
`endif

    // Random episodes checked by the reference model alone.
    sb_on = 1'b0;
    for (int i = 0; i < 60; i++) begin
      mask = ($urandom_range(0, 2) == 0) ? ONES : 4'($urandom_range(0, 15));
      drive(mask, $urandom_range(1, 40));
    end
    drive(ONES, 40);
    check("final_idle", key_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
